mips_mc_sequencer: RTL and testbench
====================================

// Module: mips_mc_sequencer
// PURPOSE
//  Multi-cycle sequencer for the basic MIPS datapath: steps each instruction through
//  FETCH/DECODE/EXEC/MEM/WB and drives PC, IR, register-file and memory strobes.
//  Sits beside the opcode control decoder, which still supplies the ALU and mux selects.
//  Handles instruction/data memory handshakes, external stall, illegal opcodes and memory timeout.
// PARAMETERS
//  OPW   6   opcode width
//  TMO   15  max cycles waiting in MEM for dmem_ack (1..255)
//  CNTW  16  retired-instruction counter width
// PORTS
//  clk       in   1     single clock, rising edge
//  rst_n     in   1     reset, synchronous, active-low
//  opcode    in   OPW   opcode field of the instruction register
//  imem_ack  in   1     instruction word valid this cycle
//  dmem_ack  in   1     data memory access complete this cycle
//  stall     in   1     external hold request
//  imem_req  out  1     instruction fetch request
//  ir_we     out  1     load instruction register
//  pc_we     out  1     advance PC
//  dmem_req  out  1     data memory request
//  dmem_we   out  1     data memory write (valid with dmem_req)
//  rf_we     out  1     register-file write strobe
//  state_o   out  3     current state encoding
//  illegal   out  1     one-cycle pulse: unsupported opcode discarded
//  timeout   out  1     sticky: a MEM access timed out; cleared only by reset
//  retired   out  CNTW  retired count (see CONFIGURATION)
// BEHAVIOUR
//  - States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Codes 5-7 are unreachable; if entered, go to FETCH.
//  - Reset: rst_n low at a clock edge puts the block in FETCH. Timeout counter, class regs, timeout, illegal and retired are cleared.
//    Outputs: state-decoded and Mealy outputs follow the FETCH state, and all registered flags read 0.
//  - Reset mid-operation aborts the instruction. No rf_we or dmem_req is asserted after the reset edge.
//  - FETCH: imem_req=1. When imem_ack=1 and stall=0: ir_we=1 and pc_we=1 in the same cycle (combinational on ack), next state DECODE.
//  - DECODE (1 cycle): register opclass {legal, is_mem, is_store} from opcode. Later IR changes are ignored.
//    - Legal opcodes: ADD 01, SUB 02, INC 03, DEC 04, AND 05, OR 06, XOR 07, NOT 08, SLL 09, SRL 0A,
//      ADDI 0B, SUBI 0C, LW 22, SW 24 (hex).
//    - Illegal opcode: illegal=1 the following cycle, go to FETCH, no writes.
//  - EXEC (1 cycle): go to MEM if is_mem, else WB.
//  - MEM: dmem_req=1 and dmem_we=is_store.
//    - On dmem_ack: LW goes to WB; SW goes to FETCH (retires).
//    - Wait counter increments each non-stalled cycle without ack. When it reaches TMO, set timeout, go to FETCH, no rf_we.
//    - If ack and the TMO limit occur in the same cycle, ack wins.
//  - WB: rf_we=1 for exactly one cycle, then FETCH (retires).
//  - stall=1: state and wait counter hold. pc_we, ir_we and rf_we are forced 0. imem_req, dmem_req and dmem_we hold their level.
//  - Acks arriving outside their own state are ignored.
//  - Latency with zero-wait acks: ALU ops 4 cycles, LW 5, SW 4 (FETCH to next FETCH).
// CONFIGURATION
//  - MIPS_MC_SEQ_RETIRE_CNT_EN defined:
//    - retired increments by 1 at each WB exit and each SW completion. Illegal or timed-out instructions do not count.
//    - Wraps modulo 2^CNTW. Does not increment while stall=1.
//  - Not defined: retired is tied to 0 and no counter flops are built. Port list is unchanged.
// STRUCTURE
//  - Shared package mips_pkg holds:
//    - opcode constants (shared with the control decoder);
//    - state encoding localparams FETCH..WB;
//    - opclass bit positions.
//  - One sub-module: mips_opclass_decode, combinational opcode -> {legal, is_mem, is_store}.
//  - Top module holds the FSM, the wait counter, flags and the optional retire counter.
// TESTING
//  - ADD (01), all acks immediate: states 0,1,2,4,0. pc_we and ir_we high in cycle 0, rf_we high in cycle 3, retired=1.
//  - LW (22), dmem_ack after 3 MEM cycles: dmem_req high 3 cycles with dmem_we=0, then rf_we one cycle. SW (24): dmem_we=1, no rf_we.
//  - Opcode 3F: illegal pulses once after DECODE, back to FETCH, no rf_we or dmem_req, retired unchanged.
//  - SW with no ack, TMO=15: dmem_req high 15 cycles, then timeout=1 (stays 1), FETCH. With ack on cycle 15: no timeout.
//  - stall=1 for 5 cycles in MEM and in WB: state frozen, rf_we 0 until release, counter frozen. Fetch is later granted normally.
//  - Mid-LW reset (rst_n=0 in MEM): next cycle state_o=0, dmem_req=0, timeout=0, retired=0. With macro undefined: retired stays 0 throughout.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, sequencer state encoding and opclass bit positions.
// Used by the multi-cycle sequencer (optional retire counter: MIPS_MC_SEQ_RETIRE_CNT_EN).
package mips_pkg;

    localparam int OPC_W = 6;

    localparam logic [OPC_W-1:0] OP_ADD  = 6'h01;
    localparam logic [OPC_W-1:0] OP_SUB  = 6'h02;
    localparam logic [OPC_W-1:0] OP_INC  = 6'h03;
    localparam logic [OPC_W-1:0] OP_DEC  = 6'h04;
    localparam logic [OPC_W-1:0] OP_AND  = 6'h05;
    localparam logic [OPC_W-1:0] OP_OR   = 6'h06;
    localparam logic [OPC_W-1:0] OP_XOR  = 6'h07;
    localparam logic [OPC_W-1:0] OP_NOT  = 6'h08;
    localparam logic [OPC_W-1:0] OP_SLL  = 6'h09;
    localparam logic [OPC_W-1:0] OP_SRL  = 6'h0A;
    localparam logic [OPC_W-1:0] OP_ADDI = 6'h0B;
    localparam logic [OPC_W-1:0] OP_SUBI = 6'h0C;
    localparam logic [OPC_W-1:0] OP_LW   = 6'h22;
    localparam logic [OPC_W-1:0] OP_SW   = 6'h24;

    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;

    typedef enum logic [2:0] {
        ST_FETCH  = FETCH,
        ST_DECODE = DECODE,
        ST_EXEC   = EXEC,
        ST_MEM    = MEM,
        ST_WB     = WB
    } seq_state_t;

    localparam int OC_LEGAL = 2;
    localparam int OC_MEM   = 1;
    localparam int OC_STORE = 0;

    typedef logic [2:0] opclass_t;

endpackage

// File: rtl/mips_mc_sequencer_if.sv
// Sequencer <-> datapath signal bundle; the sequencer uses the slave modport.
// Retired count is meaningful only with MIPS_MC_SEQ_RETIRE_CNT_EN.
interface mips_mc_sequencer_if #(
    parameter int OPW  = 6,
    parameter int CNTW = 16
);
    logic [OPW-1:0]  opcode;
    logic            imem_ack;
    logic            dmem_ack;
    logic            stall;
    logic            imem_req;
    logic            ir_we;
    logic            pc_we;
    logic            dmem_req;
    logic            dmem_we;
    logic            rf_we;
    logic [2:0]      state_o;
    logic            illegal;
    logic            timeout;
    logic [CNTW-1:0] retired;

    modport master (
        output opcode, imem_ack, dmem_ack, stall,
        input  imem_req, ir_we, pc_we, dmem_req, dmem_we, rf_we,
        input  state_o, illegal, timeout, retired
    );

    modport slave (
        input  opcode, imem_ack, dmem_ack, stall,
        output imem_req, ir_we, pc_we, dmem_req, dmem_we, rf_we,
        output state_o, illegal, timeout, retired
    );
endinterface

// File: rtl/mips_opclass_decode.sv
// Combinational opcode classifier: {legal, is_mem, is_store}.
// Independent of MIPS_MC_SEQ_RETIRE_CNT_EN.
module mips_opclass_decode
    import mips_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [OPW-1:0] opcode,
    output opclass_t       opclass
);
    always_comb begin
        opclass = '0;
        case (opcode)
            OPW'(OP_ADD), OPW'(OP_SUB), OPW'(OP_INC), OPW'(OP_DEC),
            OPW'(OP_AND), OPW'(OP_OR),  OPW'(OP_XOR), OPW'(OP_NOT),
            OPW'(OP_SLL), OPW'(OP_SRL), OPW'(OP_ADDI), OPW'(OP_SUBI):
                opclass[OC_LEGAL] = 1'b1;
            OPW'(OP_LW): begin
                opclass[OC_LEGAL] = 1'b1;
                opclass[OC_MEM]   = 1'b1;
            end
            OPW'(OP_SW): begin
                opclass[OC_LEGAL] = 1'b1;
                opclass[OC_MEM]   = 1'b1;
                opclass[OC_STORE] = 1'b1;
            end
            default: opclass = '0;
        endcase
    end
endmodule

// File: rtl/mips_mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeout and stall hold.
// Define MIPS_MC_SEQ_RETIRE_CNT_EN to build the retired-instruction counter.
//
// state  | meaning
// FETCH  | request instruction; load IR and advance PC on imem_ack
// DECODE | classify opcode; illegal opcodes return to FETCH
// EXEC   | one-cycle ALU step; memory ops go to MEM
// MEM    | data access, bounded by TMO non-stalled cycles
// WB     | one-cycle register-file write
module mips_mc_sequencer
    import mips_pkg::*;
#(
    parameter int OPW  = 6,
    parameter int TMO  = 15,
    parameter int CNTW = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    mips_mc_sequencer_if.slave  bus
);
    seq_state_t state, state_nx;
    opclass_t   dec_cls, cls_q;
    logic [7:0] wait_cnt;
    logic       tmo_hit;
    logic       ill_set;
    logic       illegal_q;
    logic       timeout_q;

    mips_opclass_decode #(.OPW(OPW)) u_dec (
        .opcode  (bus.opcode),
        .opclass (dec_cls)
    );

    always_comb begin
        state_nx     = state;
        tmo_hit      = 1'b0;
        ill_set      = 1'b0;
        bus.imem_req = 1'b0;
        bus.ir_we    = 1'b0;
        bus.pc_we    = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        bus.rf_we    = 1'b0;
        case (state)
            ST_FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ack && !bus.stall) begin
                    bus.ir_we = 1'b1;
                    bus.pc_we = 1'b1;
                    state_nx  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!bus.stall) begin
                    if (dec_cls[OC_LEGAL]) begin
                        state_nx = ST_EXEC;
                    end else begin
                        ill_set  = 1'b1;
                        state_nx = ST_FETCH;
                    end
                end
            end
            ST_EXEC: begin
                if (!bus.stall) state_nx = cls_q[OC_MEM] ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = cls_q[OC_STORE];
                if (!bus.stall) begin
                    // ack takes priority over a limit reached in the same cycle
                    if (bus.dmem_ack) begin
                        state_nx = cls_q[OC_STORE] ? ST_FETCH : ST_WB;
                    end else if (wait_cnt == 8'(TMO - 1)) begin
                        tmo_hit  = 1'b1;
                        state_nx = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                if (!bus.stall) begin
                    bus.rf_we = 1'b1;
                    state_nx  = ST_FETCH;
                end
            end
            default: state_nx = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_FETCH;
            cls_q     <= '0;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nx;
            illegal_q <= ill_set;
            if (tmo_hit) timeout_q <= 1'b1;
            if (state == ST_DECODE && !bus.stall) cls_q <= dec_cls;
            if (state != ST_MEM) begin
                wait_cnt <= '0;
            end else if (!bus.stall && !bus.dmem_ack) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    assign bus.state_o = state;
    assign bus.illegal = illegal_q;
    assign bus.timeout = timeout_q;

`ifdef MIPS_MC_SEQ_RETIRE_CNT_EN
    logic [CNTW-1:0] retire_q;
    logic            retire_evt;

    assign retire_evt = !bus.stall &&
                        ((state == ST_WB) ||
                         (state == ST_MEM && bus.dmem_ack && cls_q[OC_STORE]));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retire_q <= '0;
        end else if (retire_evt) begin
            retire_q <= retire_q + 1'b1;
        end
    end

    assign bus.retired = retire_q;
`else
    assign bus.retired = {CNTW{1'b0}};
`endif

endmodule

// File: tb/tb_mips_mc_sequencer.sv
// Directed self-checking bench for mips_mc_sequencer (TMO=15, CNTW=16).
// Expected retired count depends on MIPS_MC_SEQ_RETIRE_CNT_EN.
module tb_mips_mc_sequencer;
    localparam int OPW  = 6;
    localparam int TMO  = 15;
    localparam int CNTW = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   exp_ret = 0;

    mips_mc_sequencer_if #(.OPW(OPW), .CNTW(CNTW)) bus ();

    mips_mc_sequencer #(.OPW(OPW), .TMO(TMO), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] opc, input logic iack, input logic dack, input logic stl);
        bus.opcode   = opc;
        bus.imem_ack = iack;
        bus.dmem_ack = dack;
        bus.stall    = stl;
        #1;
    endtask

    task automatic retire();
`ifdef MIPS_MC_SEQ_RETIRE_CNT_EN
        exp_ret++;
`endif
    endtask

    // FETCH(ack) -> DECODE -> EXEC; returns at the first MEM/WB cycle
    task automatic fde(input logic [5:0] opc, input string tag);
        drive(opc, 1'b1, 1'b0, 1'b0);
        chk({tag, "_f_pc_we"}, 32'(bus.pc_we), 32'd1);
        chk({tag, "_f_ir_we"}, 32'(bus.ir_we), 32'd1);
        tick();
        drive(opc, 1'b0, 1'b0, 1'b0);
        chk({tag, "_d_state"}, 32'(bus.state_o), 32'd1);
        tick();
        drive(6'h3F, 1'b0, 1'b0, 1'b0);
        chk({tag, "_e_state"}, 32'(bus.state_o), 32'd2);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(6'h00, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_state",   32'(bus.state_o), 32'd0);
        chk("rst_imemreq", 32'(bus.imem_req), 32'd1);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);
        chk("rst_retired", 32'(bus.retired), 32'd0);
        rst_n = 1'b1;

        // ADD: 0,1,2,4,0
        fde(6'h01, "add");
        drive(6'h00, 1'b0, 1'b0, 1'b0);
        chk("add_wb_state", 32'(bus.state_o), 32'd4);
        chk("add_wb_rfwe",  32'(bus.rf_we), 32'd1);
        retire();
        tick();
        drive(6'h00, 1'b0, 1'b0, 1'b0);
        chk("add_end_state", 32'(bus.state_o), 32'd0);
        chk("add_end_rfwe",  32'(bus.rf_we), 32'd0);
        chk("add_retired",   32'(bus.retired), 32'(exp_ret));

        // LW with ack on the third MEM cycle; opcode changed after DECODE
        fde(6'h22, "lw");
        for (int i = 0; i < 3; i++) begin
            drive(6'h3F, 1'b0, (i == 2), 1'b0);
            chk($sformatf("lw_m%0d_state", i), 32'(bus.state_o), 32'd3);
            chk($sformatf("lw_m%0d_req", i), 32'(bus.dmem_req), 32'd1);
            chk($sformatf("lw_m%0d_we", i), 32'(bus.dmem_we), 32'd0);
            tick();
        end
        drive(6'h00, 1'b0, 1'b0, 1'b0);
        chk("lw_wb_rfwe", 32'(bus.rf_we), 32'd1);
        chk("lw_wb_req",  32'(bus.dmem_req), 32'd0);
        retire();
        tick();
        drive(6'h00, 1'b0, 1'b0, 1'b0);
        chk("lw_end_state", 32'(bus.state_o), 32'd0);
        chk("lw_retired",   32'(bus.retired), 32'(exp_ret));

        // SW, immediate ack
        fde(6'h24, "sw");
        drive(6'h00, 1'b0, 1'b1, 1'b0);
        chk("sw_m_we",   32'(bus.dmem_we), 32'd1);
        chk("sw_m_rfwe", 32'(bus.rf_we), 32'd0);
        retire();
        tick();
        drive(6'h00, 1'b0, 1'b0, 1'b0);
        chk("sw_end_state", 32'(bus.state_o), 32'd0);
        chk("sw_retired",   32'(bus.retired), 32'(exp_ret));

        // illegal opcode 3F
        drive(6'h3F, 1'b1, 1'b0, 1'b0);
        tick();
        drive(6'h3F, 1'b0, 1'b0, 1'b0);
        chk("ill_d_state", 32'(bus.state_o), 32'd1);
        chk("ill_d_flag",  32'(bus.illegal), 32'd0);
        tick();
        drive(6'h00, 1'b0, 1'b0, 1'b0);
        chk("ill_state",   32'(bus.state_o), 32'd0);
        chk("ill_pulse",   32'(bus.illegal), 32'd1);
        chk("ill_rfwe",    32'(bus.rf_we), 32'd0);
        chk("ill_dmemreq", 32'(bus.dmem_req), 32'd0);
        tick();
        drive(6'h00, 1'b0, 1'b0, 1'b0);
        chk("ill_pulse_end", 32'(bus.illegal), 32'd0);
        chk("ill_retired",   32'(bus.retired), 32'(exp_ret));

        // LW with stall inside MEM: 3 run, 5 stalled (ack ignored), 11 run, ack
        fde(6'h22, "stl");
        for (int i = 0; i < 19; i++) begin
            drive(6'h00, 1'b0, (i >= 3 && i < 8), (i >= 3 && i < 8));
            chk($sformatf("stl_m%0d_state", i), 32'(bus.state_o), 32'd3);
            tick();
        end
        drive(6'h00, 1'b0, 1'b1, 1'b0);
        chk("stl_mlast_state", 32'(bus.state_o), 32'd3);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(6'h00, 1'b0, 1'b0, 1'b1);
            chk($sformatf("stl_wb%0d_state", i), 32'(bus.state_o), 32'd4);
            chk($sformatf("stl_wb%0d_rfwe", i), 32'(bus.rf_we), 32'd0);
            chk($sformatf("stl_wb%0d_ret", i), 32'(bus.retired), 32'(exp_ret));
            tick();
        end
        drive(6'h00, 1'b0, 1'b0, 1'b0);
        chk("stl_wb_rel_rfwe", 32'(bus.rf_we), 32'd1);
        chk("stl_timeout",     32'(bus.timeout), 32'd0);
        retire();
        tick();
        drive(6'h01, 1'b1, 1'b0, 1'b1);
        chk("stl_f_pcwe",  32'(bus.pc_we), 32'd0);
        chk("stl_f_ireq",  32'(bus.imem_req), 32'd1);
        chk("stl_retired", 32'(bus.retired), 32'(exp_ret));
        tick();
        drive(6'h01, 1'b1, 1'b0, 1'b0);
        chk("stl_f_state", 32'(bus.state_o), 32'd0);
        chk("stl_f_grant", 32'(bus.pc_we), 32'd1);
        tick();
        tick();
        tick();
        tick();
        retire();
        drive(6'h00, 1'b0, 1'b0, 1'b0);
        chk("stl_add_done", 32'(bus.state_o), 32'd0);

        // SW with ack on the 15th MEM cycle: ack wins
        fde(6'h24, "swa");
        for (int i = 0; i < TMO; i++) begin
            drive(6'h00, 1'b0, (i == TMO - 1), 1'b0);
            chk($sformatf("swa_m%0d_req", i), 32'(bus.dmem_req), 32'd1);
            tick();
        end
        retire();
        drive(6'h00, 1'b0, 1'b0, 1'b0);
        chk("swa_state",   32'(bus.state_o), 32'd0);
        chk("swa_timeout", 32'(bus.timeout), 32'd0);
        chk("swa_retired", 32'(bus.retired), 32'(exp_ret));

        // SW with no ack: timeout after 15 MEM cycles
        fde(6'h24, "swt");
        for (int i = 0; i < TMO; i++) begin
            drive(6'h00, 1'b0, 1'b0, 1'b0);
            chk($sformatf("swt_m%0d_state", i), 32'(bus.state_o), 32'd3);
            chk($sformatf("swt_m%0d_to", i), 32'(bus.timeout), 32'd0);
            tick();
        end
        drive(6'h00, 1'b0, 1'b0, 1'b0);
        chk("swt_state",   32'(bus.state_o), 32'd0);
        chk("swt_timeout", 32'(bus.timeout), 32'd1);
        chk("swt_rfwe",    32'(bus.rf_we), 32'd0);
        chk("swt_retired", 32'(bus.retired), 32'(exp_ret));
        tick();
        tick();
        drive(6'h00, 1'b0, 1'b0, 1'b0);
        chk("swt_sticky", 32'(bus.timeout), 32'd1);

        // reset in the middle of a LW
        fde(6'h22, "rst");
        drive(6'h00, 1'b0, 1'b0, 1'b0);
        chk("rst_m_state", 32'(bus.state_o), 32'd3);
        rst_n = 1'b0;
        tick();
        drive(6'h00, 1'b0, 1'b1, 1'b0);
        chk("mrst_state",   32'(bus.state_o), 32'd0);
        chk("mrst_dmemreq", 32'(bus.dmem_req), 32'd0);
        chk("mrst_rfwe",    32'(bus.rf_we), 32'd0);
        chk("mrst_timeout", 32'(bus.timeout), 32'd0);
        chk("mrst_retired", 32'(bus.retired), 32'd0);
        rst_n = 1'b1;
        tick();
        drive(6'h00, 1'b0, 1'b0, 1'b0);
        chk("mrst_idle_state", 32'(bus.state_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
